// File: rtl/seq_mlp_engine.sv
// Sequential MLP engine: one shared signed MAC evaluates an N_IN-input, N_HID-neuron hidden
// layer and a single output neuron, using a write-loaded weight file and valid/ready handshakes.
module seq_mlp_engine #(
    parameter int N_IN     = 4,
    parameter int N_HID    = 3,
    parameter int DW       = 8,
    parameter int FRAC     = 4,
    parameter int ACC_W    = 20,
    parameter int ACT_MODE = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N_IN*DW-1:0]                    in_data,
    input  logic                                  w_wr_en,
    input  logic [$clog2(N_HID*(N_IN+2)+1)-1:0]   w_wr_addr,
    input  logic [DW-1:0]                         w_wr_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DW-1:0]                         out_data,
    output logic                                  busy
);

    localparam int NW     = N_HID*(N_IN+2)+1;
    localparam int AW     = $clog2(NW);
    localparam int IW     = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int JW     = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int B_BASE = N_IN*N_HID;
    localparam int V_BASE = N_HID*(N_IN+1);
    localparam int C_ADDR = N_HID*(N_IN+2);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DW-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [DW-1:0]    ONE_Q   = DW'(1 << FRAC);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HMAC = 3'd1,
        S_HACT = 3'd2,
        S_OMAC = 3'd3,
        S_OACT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nx;
    logic signed [DW-1:0]     r_wf [NW];
    logic signed [DW-1:0]     r_x  [N_IN];
    logic signed [DW-1:0]     r_h  [N_HID];
    logic [IW-1:0]            r_i;
    logic [JW-1:0]            r_j;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_busy;
    logic [DW-1:0]            r_out_data;

    logic                     w_last_i;
    logic                     w_last_j;
    logic                     w_accept;
    logic                     w_wr_ok;
    logic [AW-1:0]            w_rd_addr;
    logic signed [DW-1:0]     w_rd_word;
    logic signed [DW-1:0]     w_mul_a;
    logic signed [2*DW-1:0]   w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_bias_ext;

    // Rescale, clamp to the DW range, then apply the selected activation.
    function automatic logic signed [DW-1:0] f_act(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        logic signed [DW-1:0]    s;
        sh = a >>> FRAC;
        if (sh > SAT_MAX) begin
            s = SAT_MAX[DW-1:0];
        end else if (sh < SAT_MIN) begin
            s = SAT_MIN[DW-1:0];
        end else begin
            s = sh[DW-1:0];
        end
        if (ACT_MODE == 0) begin
            f_act = s[DW-1] ? {DW{1'b0}} : s;
        end else begin
            f_act = (!s[DW-1] && (s != {DW{1'b0}})) ? ONE_Q : {DW{1'b0}};
        end
    endfunction

    assign w_last_i   = (r_i == IW'(N_IN-1));
    assign w_last_j   = (r_j == JW'(N_HID-1));
    assign w_accept   = (r_state == S_IDLE) && in_valid;
    assign w_wr_ok    = w_wr_en && (r_state == S_IDLE) && (32'(w_wr_addr) < NW);
    assign w_rd_word  = r_wf[w_rd_addr];
    assign w_prod     = w_mul_a * w_rd_word;
    assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-DW-FRAC){w_rd_word[DW-1]}}, w_rd_word, {FRAC{1'b0}}};

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  w_state_nx = in_valid  ? S_HMAC : S_IDLE;
            S_HMAC:  w_state_nx = w_last_i  ? S_HACT : S_HMAC;
            S_HACT:  w_state_nx = w_last_j  ? S_OMAC : S_HMAC;
            S_OMAC:  w_state_nx = w_last_j  ? S_OACT : S_OMAC;
            S_OACT:  w_state_nx = S_DONE;
            S_DONE:  w_state_nx = out_ready ? S_IDLE : S_DONE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Weight-file read address and MAC operand select; in HACT this prefetches the next bias.
    always_comb begin
        w_rd_addr = AW'(B_BASE);
        w_mul_a   = r_x[r_i];
        case (r_state)
            S_HMAC: begin
                w_rd_addr = AW'(32'(r_j)*N_IN + 32'(r_i));
            end
            S_HACT: begin
                if (w_last_j) begin
                    w_rd_addr = AW'(C_ADDR);
                end else begin
                    w_rd_addr = AW'(B_BASE + 32'(r_j) + 1);
                end
            end
            S_OMAC: begin
                w_rd_addr = AW'(V_BASE + 32'(r_j));
                w_mul_a   = r_h[r_j];
            end
            default: begin
                w_rd_addr = AW'(B_BASE);
            end
        endcase
    end

    // Weight/bias register file, writable only while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NW; k++) r_wf[k] <= {DW{1'b0}};
        end else if (w_wr_ok) begin
            r_wf[w_wr_addr] <= w_wr_data;
        end
    end

    // Datapath, sequencing counters and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_IN; k++)  r_x[k] <= {DW{1'b0}};
            for (int k = 0; k < N_HID; k++) r_h[k] <= {DW{1'b0}};
            r_i         <= {IW{1'b0}};
            r_j         <= {JW{1'b0}};
            r_acc       <= {ACC_W{1'b0}};
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_out_data  <= {DW{1'b0}};
        end else begin
            r_in_ready <= (w_state_nx == S_IDLE);
            r_busy     <= (w_state_nx != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        for (int k = 0; k < N_IN; k++) r_x[k] <= in_data[k*DW +: DW];
                        r_i   <= {IW{1'b0}};
                        r_j   <= {JW{1'b0}};
                        r_acc <= w_bias_ext;
                    end
                end
                S_HMAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_i   <= w_last_i ? {IW{1'b0}} : r_i + 1'b1;
                end
                S_HACT: begin
                    r_h[r_j] <= f_act(r_acc);
                    r_acc    <= w_bias_ext;
                    r_i      <= {IW{1'b0}};
                    r_j      <= w_last_j ? {JW{1'b0}} : r_j + 1'b1;
                end
                S_OMAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_j   <= w_last_j ? {JW{1'b0}} : r_j + 1'b1;
                end
                S_OACT: begin
                    r_out_data  <= f_act(r_acc);
                    r_out_valid <= 1'b1;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mlp_engine.sv
// Directed, table-driven bench for seq_mlp_engine; a second instance runs the step activation.
module tb_seq_mlp_engine;

    localparam int N_IN = 4;
    localparam int NW   = 19;
    localparam int LAT  = 19;

    typedef struct {
        string      name;
        logic [7:0] w;
        logic [7:0] v;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] x;
        int         exp_relu;
        int         exp_step;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         w_wr_en;
    logic [4:0]   w_wr_addr;
    logic [7:0]   w_wr_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         busy;
    logic         s_in_ready;
    logic         s_out_valid;
    logic [7:0]   s_out_data;
    logic         s_busy;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs [6];

    seq_mlp_engine #(.ACT_MODE(0)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    seq_mlp_engine #(.ACT_MODE(1)) u_step (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        w_wr_en   = 1'b1;
        w_wr_addr = a;
        w_wr_data = d;
        @(posedge clk); #1;
        w_wr_en   = 1'b0;
    endtask

    task automatic load(input logic [7:0] w, input logic [7:0] v, input logic [7:0] b,
                        input logic [7:0] c);
        for (int a = 0; a < NW; a++) begin
            if (a < 12)      wr(5'(a), w);
            else if (a < 15) wr(5'(a), b);
            else if (a < 18) wr(5'(a), v);
            else             wr(5'(a), c);
        end
    endtask

    task automatic start(input logic [7:0] x);
        in_valid = 1'b1;
        in_data  = {N_IN{x}};
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int got;
        int got_s;

        vecs[0] = '{"basic",      8'd16,  8'd16,  8'd0,   8'd0,   8'd4,   48,  16};
        vecs[1] = '{"relu_bias",  8'hF0,  8'd16,  8'd0,   8'd8,   8'd16,  8,   16};
        vecs[2] = '{"saturate",   8'd127, 8'd127, 8'd0,   8'd0,   8'd127, 127, 16};
        vecs[3] = '{"trunc_pos",  8'hFD,  8'd16,  8'd16,  8'hF8,  8'd1,   37,  16};
        vecs[4] = '{"neg_out",    8'd0,   8'd16,  8'd0,   8'hFF,  8'd4,   0,   0};
        vecs[5] = '{"mixed",      8'd8,   8'd4,   8'hFF,  8'hFE,  8'd32,  45,  16};

        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; w_wr_en = 1'b0;
        w_wr_addr = 5'd0; w_wr_data = 8'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'(out_data),  0);
        check("rst_busy",      int'(busy),      0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zeroed weight file computes zero.
        start(8'd4);
        check("busy_after_accept", int'(busy), 1);
        wait_out(lat);
        check("zero_wf_latency", lat, LAT);
        check("zero_wf_out", int'(out_data), 0);
        handshake();

        for (int k = 0; k < 6; k++) begin
            load(vecs[k].w, vecs[k].v, vecs[k].b, vecs[k].c);
            start(vecs[k].x);
            wait_out(lat);
            got   = int'(out_data);
            got_s = int'(s_out_data);
            check({vecs[k].name, "_latency"}, lat, LAT);
            check({vecs[k].name, "_relu"}, got, vecs[k].exp_relu);
            check({vecs[k].name, "_step"}, got_s, vecs[k].exp_step);
            handshake();
        end

        // Backpressure: result held, in_valid pulses ignored.
        load(8'd16, 8'd16, 8'd0, 8'd0);
        start(8'd4);
        wait_out(lat);
        check("bp_latency", lat, LAT);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(posedge clk); #1;
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data",  int'(out_data),  48);
            check("bp_in_ready",  int'(in_ready),  0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #3;
        check("bp_in_ready_same_cycle", int'(in_ready), 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_in_ready_after", int'(in_ready), 1);
        check("bp_out_valid_after", int'(out_valid), 0);
        check("bp_out_data_held", int'(out_data), 48);
        @(posedge clk); #1;
        check("bp_no_buffered_input", int'(busy), 0);

        // Write guard: writes while busy or out of range have no effect.
        start(8'd4);
        @(posedge clk); #1;
        wr(5'd0, 8'h80);
        wait_out(lat);
        check("wg_busy_write_out", int'(out_data), 48);
        handshake();
        wr(5'(NW), 8'h55);
        start(8'd4);
        wait_out(lat);
        check("wg_next_out", int'(out_data), 48);
        check("wg_next_latency", lat, LAT);
        handshake();

        // Reset in the middle of HMAC aborts and clears everything.
        start(8'd4);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready",  int'(in_ready),  1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_out_data",  int'(out_data),  0);
        check("mid_rst_busy",      int'(busy),      0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        start(8'd4);
        wait_out(lat);
        check("post_rst_latency", lat, LAT);
        check("post_rst_out", int'(out_data), 0);
        check("post_rst_step", int'(s_out_data), 0);
        handshake();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
